hdc_bundler_bit: RTL and testbench

//  Single-bit majority bundler for the HDC encoder. Takes one bit position from NUM_HVS hypervectors.

---
 rtl/hdc_bundler_bit.sv | 122 ++++++++++++
 tb/tb_hdc_bundler_bit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdc_bundler_bit.sv
// Purpose    : single-bit majority bundler; counts NUM_HVS latched vote bits serially and emits the majority.
// Latency    : en sampled at edge E -> done/out_bit updated at edge E+NUM_HVS+1 (one count per cycle plus a decide cycle).
// Backpressure: none; en is ignored while busy (no queueing), a new en is accepted on the cycle done is high.
//
// Ports:
//   clk      rising-edge clock
//   nrst     asynchronous active-low reset
//   en       start pulse; bits/tie_1/tie_2 are captured on the edge where en=1 while idle
//   bits     NUM_HVS vote bits, one per hypervector (unpacked)
//   tie_1    tie-break bit A (only matters for even NUM_HVS)
//   tie_2    tie-break bit B (only matters for even NUM_HVS)
//   done     one-cycle pulse marking a fresh out_bit
//   out_bit  registered majority bit, held until the next result
module hdc_bundler_bit #(
  parameter int NUM_HVS = 6
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic bits [NUM_HVS-1:0],
  input  logic tie_1,
  input  logic tie_2,
  output logic done,
  output logic out_bit
);

  // Counter must hold the value NUM_HVS itself (all ones set).
  localparam int CW = $clog2(NUM_HVS + 1);
  // Index only needs to reach NUM_HVS-1; keep at least one bit.
  localparam int IW = (NUM_HVS > 2) ? $clog2(NUM_HVS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_DECIDE = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [IW-1:0]        index;
  logic [NUM_HVS-1:0]   bits_l;
  logic                 tie_1_l;
  logic                 tie_2_l;

  // Packed view of the unpacked vote inputs so they can be captured in one register.
  logic [NUM_HVS-1:0]   bits_pk;

  always_comb begin
    bits_pk = '0;
    for (int i = 0; i < NUM_HVS; i++) begin
      bits_pk[i] = bits[i];
    end
  end

  // Majority decision on the final count. Doubling the count into CW+1 bits
  // avoids halving NUM_HVS, so odd and even sizes share one comparison and
  // nothing can overflow. The equality case only arises for even NUM_HVS.
  logic [CW:0] twice_count;
  logic [CW:0] num_hvs_w;
  logic        majority;

  assign twice_count = {count, 1'b0};
  assign num_hvs_w   = (CW + 1)'(NUM_HVS);

  always_comb begin
    majority = 1'b0;
    if (twice_count > num_hvs_w) begin
      majority = 1'b1;
    end else if (twice_count < num_hvs_w) begin
      majority = 1'b0;
    end else begin
      majority = tie_1_l ^ tie_2_l;
    end
  end

  // Single registered FSM; done is a pulse, so it defaults low every edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= S_IDLE;
      count   <= '0;
      index   <= '0;
      bits_l  <= '0;
      tie_1_l <= 1'b0;
      tie_2_l <= 1'b0;
      done    <= 1'b0;
      out_bit <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            bits_l  <= bits_pk;
            tie_1_l <= tie_1;
            tie_2_l <= tie_2;
            count   <= '0;
            index   <= '0;
            state   <= S_COUNT;
          end
        end

        S_COUNT: begin
          count <= count + CW'(bits_l[index]);
          index <= index + IW'(1);
          if (index == IW'(NUM_HVS - 1)) begin
            state <= S_DECIDE;
          end
        end

        S_DECIDE: begin
          out_bit <= majority;
          done    <= 1'b1;
          state   <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdc_bundler_bit.sv
module tb_hdc_bundler_bit;

  localparam int N = 6;
  localparam int LAT = N + 1;

  logic clk;
  logic nrst;
  logic en;
  logic bits [N-1:0];
  logic tie_1;
  logic tie_2;
  logic done;
  logic out_bit;

  int vectors;
  int miscompares;

  hdc_bundler_bit #(.NUM_HVS(N)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .bits    (bits),
    .tie_1   (tie_1),
    .tie_2   (tie_2),
    .done    (done),
    .out_bit (out_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count the ones, compare against half of N, break ties by XOR.
  function automatic logic ref_majority(input logic [N-1:0] b, input logic t1, input logic t2);
    int ones;
    ones = 0;
    for (int i = 0; i < N; i++) ones += int'(b[i]);
    if (2 * ones > N) return 1'b1;
    if (2 * ones < N) return 1'b0;
    return t1 ^ t2;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_bits(input logic [N-1:0] b);
    for (int i = 0; i < N; i++) bits[i] = b[i];
  endtask

  // Must be called at a negedge. Pulses en for one cycle, waits (bounded) for
  // done, checks latency and result, and returns at the negedge showing done.
  task automatic run_vote(input string tag, input logic [N-1:0] b, input logic t1, input logic t2);
    int   lat;
    logic exp;
    exp = ref_majority(b, t1, t2);
    drive_bits(b);
    tie_1 = t1;
    tie_2 = t2;
    en    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en  = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    check_int({tag, "_latency"}, lat, LAT);
    check_bit({tag, "_out_bit"}, out_bit, exp);
  endtask

  // After run_vote: done must drop next cycle and out_bit must hold.
  task automatic check_pulse_end(input string tag, input logic held);
    @(negedge clk);
    check_bit({tag, "_done_pulse"}, done, 1'b0);
    check_bit({tag, "_hold"}, out_bit, held);
  endtask

  initial begin
    logic [N-1:0] rb;
    logic         rt1, rt2, exp;
    int           done_cnt, lat;

    vectors     = 0;
    miscompares = 0;
    nrst  = 1'b0;
    en    = 1'b0;
    tie_1 = 1'b0;
    tie_2 = 1'b0;
    drive_bits('0);

    // Reset state
    repeat (3) @(negedge clk);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_out_bit", out_bit, 1'b0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("idle_no_done", done, 1'b0);

    // 1. count 2 -> 0
    run_vote("t1", 6'b010001, 1'b0, 1'b0);
    check_pulse_end("t1", 1'b0);
    repeat (2) @(negedge clk);

    // 2. tie (3 ones), 1^0 -> 1
    run_vote("t2", 6'b001011, 1'b1, 1'b0);
    check_pulse_end("t2", 1'b1);
    repeat (2) @(negedge clk);

    // 3. tie (3 ones), 1^1 -> 0
    run_vote("t3", 6'b100011, 1'b1, 1'b1);
    check_pulse_end("t3", 1'b0);
    repeat (2) @(negedge clk);

    // 4. count 5 -> 1, then idle with en=0: no done, out_bit held
    run_vote("t4", 6'b111101, 1'b0, 1'b0);
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_int("t4_idle_done_count", done_cnt, 0);
    check_bit("t4_idle_hold", out_bit, 1'b1);

    // 5. en re-pulsed during COUNT with different inputs -> ignored
    rb  = 6'b000111;  // tie with ties 0/1 -> 1; replacement inputs would give 0
    exp = ref_majority(rb, 1'b0, 1'b1);
    drive_bits(rb);
    tie_1 = 1'b0;
    tie_2 = 1'b1;
    en    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    drive_bits(6'b000000);
    tie_1 = 1'b1;
    tie_2 = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    en = 1'b0;
    done_cnt = 0;
    lat = -1;
    // negedge index k here shows state after edge E+k+2
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k + 2;
          check_bit("t5_out_bit", out_bit, exp);
        end
      end
    end
    check_int("t5_done_count", done_cnt, 1);
    check_int("t5_latency", lat, LAT);
    check_bit("t5_hold", out_bit, exp);

    // 6. reset 3 cycles into COUNT: immediate clear, no done, then normal vote
    drive_bits(6'b111111);
    tie_1 = 1'b0;
    tie_2 = 1'b0;
    en    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    #1;
    check_bit("t6_abort_done", done, 1'b0);
    check_bit("t6_abort_out_bit", out_bit, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_int("t6_no_done_after_abort", done_cnt, 0);
    run_vote("t6_after", 6'b110110, 1'b0, 1'b0);
    check_pulse_end("t6_after", 1'b1);

    // Back-to-back: new en driven during the done cycle is accepted
    run_vote("b2b_a", 6'b000001, 1'b0, 1'b0);
    run_vote("b2b_b", 6'b011111, 1'b0, 1'b0);
    check_pulse_end("b2b_b", 1'b1);

    // Randomized votes against the reference model
    for (int n = 0; n < 40; n++) begin
      rb  = N'($urandom);
      rt1 = 1'($urandom);
      rt2 = 1'($urandom);
      run_vote($sformatf("rand%0d", n), rb, rt1, rt2);
      exp = ref_majority(rb, rt1, rt2);
      if ($urandom_range(0, 1) == 0) begin
        check_pulse_end($sformatf("rand%0d", n), exp);
      end
      // Scramble inputs while idle; they must not matter until the next en
      drive_bits(N'($urandom));
      tie_1 = 1'($urandom);
      tie_2 = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
